mux_arbiter: RTL and testbench

Two-requester round-robin arbiter that shares the team's 2:1 `mux` datapath between requester A (input `a`) and requester B (input `b`). It owns the mux select line, issues mutually exclusive grants with a registered handshake, and registers the selected data with a valid flag. It sits directly in front of a `mux` instance (or its inline equivalent) wherever two producers contend for one output.

---
 rtl/mux_arbiter.sv | 122 ++++++++++++
 tb/tb_mux_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_arbiter.sv
// Round-robin arbiter owning the select of a shared 2:1 mux, with
// registered grants and a registered, valid-flagged mux output.
//
// Parameters:
//   WIDTH     data width of a, b, m_out
//   MAX_HOLD  grant cycles before forced handover (2..255)
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   req_a, req_b      requests, held high for the whole transfer
//   a, b              requester data
//   gnt_a, gnt_b      registered, mutually exclusive grants
//   sel               registered mux select (0 = a, 1 = b)
//   m_out, m_valid    registered mux output and its valid flag
// Build option:
//   MUX_ARB_TIMEOUT_EN  preempt an owner after MAX_HOLD cycles
//                       while the other side is waiting
module mux_arbiter #(
    parameter int WIDTH    = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             sel,
    output logic [WIDTH-1:0] m_out,
    output logic             m_valid
);

    typedef enum logic [1:0] {
        IDLE,
        OWN_A,
        OWN_B
    } state_t;

    state_t state;
    state_t nxt;
    logic   last;
    logic   expire;

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
        $error("mux_arbiter: MAX_HOLD must be in 2..255");
    end

`ifdef MUX_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] hcnt;

    // Owner has used its last allowed cycle.
    assign expire = (hcnt == HOLD_LAST);
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: begin
                if (req_a && req_b)
                    nxt = last ? OWN_A : OWN_B;
                else if (req_a)
                    nxt = OWN_A;
                else if (req_b)
                    nxt = OWN_B;
            end
            OWN_A: begin
                if (!req_a || (req_b && expire))
                    nxt = req_b ? OWN_B : IDLE;
            end
            OWN_B: begin
                if (!req_b || (req_a && expire))
                    nxt = req_a ? OWN_A : IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            last    <= 1'b1;
            gnt_a   <= 1'b0;
            gnt_b   <= 1'b0;
            sel     <= 1'b0;
            m_out   <= '0;
            m_valid <= 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
            hcnt    <= '0;
`endif
        end else begin
            state <= nxt;
            gnt_a <= (nxt == OWN_A);
            gnt_b <= (nxt == OWN_B);

            if (nxt == OWN_A && state != OWN_A) begin
                last <= 1'b0;
                sel  <= 1'b0;
            end else if (nxt == OWN_B && state != OWN_B) begin
                last <= 1'b1;
                sel  <= 1'b1;
            end

`ifdef MUX_ARB_TIMEOUT_EN
            if (nxt != state)
                hcnt <= '0;
            else if (state != IDLE && hcnt != 8'hff)
                hcnt <= hcnt + 8'd1;
`endif

            // Datapath trails the grant by one cycle.
            m_valid <= gnt_a | gnt_b;
            if (gnt_a | gnt_b)
                m_out <= gnt_b ? b : a;
        end
    end

endmodule

// File: tb/tb_mux_arbiter.sv
// Self-checking bench for mux_arbiter.
// Per-cycle expectations are queued with the stimulus and checked after the edge.
module tb_mux_arbiter;

    localparam int W = 4;

    typedef struct packed {
        logic         rst;
        logic         ra;
        logic         rb;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W+3:0] exp;
    } row_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_a = 1'b0;
    logic         req_b = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         gnt_a;
    logic         gnt_b;
    logic         sel;
    logic [W-1:0] m_out;
    logic         m_valid;

    int checks = 0;
    int errors = 0;
    logic [W+3:0] sb[$];

    mux_arbiter #(.WIDTH(W), .MAX_HOLD(4)) dut (
        .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b),
        .a(a), .b(b), .gnt_a(gnt_a), .gnt_b(gnt_b), .sel(sel),
        .m_out(m_out), .m_valid(m_valid)
    );

    always #5 clk = ~clk;

    function automatic row_t mk(
        input logic r, input logic qa, input logic qb,
        input logic [W-1:0] da, input logic [W-1:0] db,
        input logic ga, input logic gb, input logic s,
        input logic mv, input logic [W-1:0] mo);
        row_t t;
        t.rst = r;
        t.ra  = qa;
        t.rb  = qb;
        t.a   = da;
        t.b   = db;
        t.exp = {ga, gb, s, mv, mo};
        return t;
    endfunction

    // Drive one cycle of stimulus and queue what must appear after the edge.
    task automatic drive(input row_t t);
        rst   = t.rst;
        req_a = t.ra;
        req_b = t.rb;
        a     = t.a;
        b     = t.b;
        sb.push_back(t.exp);
    endtask

    function automatic logic [W+3:0] obs();
        return {gnt_a, gnt_b, sel, m_valid, m_out};
    endfunction

    task automatic test_reset();
        row_t t[$];
        logic [W+3:0] e;
        t.push_back(mk(1, 1, 1, 4'h5, 4'ha, 0, 0, 0, 0, 4'h0));
        t.push_back(mk(1, 1, 1, 4'h5, 4'ha, 0, 0, 0, 0, 4'h0));
        t.push_back(mk(0, 1, 1, 4'h5, 4'ha, 1, 0, 0, 0, 4'h0));
        t.push_back(mk(0, 0, 0, 4'h5, 4'ha, 0, 0, 0, 1, 4'h5));
        t.push_back(mk(0, 0, 0, 4'h1, 4'ha, 0, 0, 0, 0, 4'h5));
        foreach (t[i]) begin
            drive(t[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL reset row %0d: got %b want %b", i, obs(), e);
            end
        end
    endtask

    task automatic test_single();
        row_t t[$];
        logic [W+3:0] e;
        t.push_back(mk(0, 1, 0, 4'h3, 4'h0, 1, 0, 0, 0, 4'h5));
        t.push_back(mk(0, 1, 0, 4'h6, 4'h0, 1, 0, 0, 1, 4'h6));
        t.push_back(mk(0, 1, 0, 4'h9, 4'h0, 1, 0, 0, 1, 4'h9));
        t.push_back(mk(0, 1, 0, 4'hc, 4'h0, 1, 0, 0, 1, 4'hc));
        t.push_back(mk(0, 0, 0, 4'h7, 4'h0, 0, 0, 0, 1, 4'h7));
        t.push_back(mk(0, 0, 0, 4'h2, 4'h0, 0, 0, 0, 0, 4'h7));
        foreach (t[i]) begin
            drive(t[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL single row %0d: got %b want %b", i, obs(), e);
            end
        end
    endtask

    task automatic test_round_robin();
        row_t t[$];
        logic [W+3:0] e;
        t.push_back(mk(0, 1, 0, 4'h1, 4'h8, 1, 0, 0, 0, 4'h7));
        t.push_back(mk(0, 1, 1, 4'h2, 4'h9, 1, 0, 0, 1, 4'h2));
        t.push_back(mk(0, 0, 1, 4'h3, 4'ha, 0, 1, 1, 1, 4'h3));
        t.push_back(mk(0, 0, 1, 4'h4, 4'hb, 0, 1, 1, 1, 4'hb));
        t.push_back(mk(0, 0, 0, 4'h4, 4'hc, 0, 0, 1, 1, 4'hc));
        t.push_back(mk(0, 1, 1, 4'h5, 4'hd, 1, 0, 0, 0, 4'hc));
        t.push_back(mk(0, 0, 0, 4'h6, 4'hd, 0, 0, 0, 1, 4'h6));
        t.push_back(mk(0, 0, 0, 4'h6, 4'hd, 0, 0, 0, 0, 4'h6));
        t.push_back(mk(0, 1, 1, 4'h1, 4'h2, 0, 1, 1, 0, 4'h6));
        t.push_back(mk(0, 0, 0, 4'h1, 4'he, 0, 0, 1, 1, 4'he));
        t.push_back(mk(0, 0, 0, 4'h1, 4'h3, 0, 0, 1, 0, 4'he));
        foreach (t[i]) begin
            drive(t[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL round_robin row %0d: got %b want %b",
                         i, obs(), e);
            end
        end
    endtask

    task automatic test_back_to_back();
        row_t t[$];
        logic [W+3:0] e;
        t.push_back(mk(0, 1, 0, 4'h0, 4'hf, 1, 0, 0, 0, 4'he));
        t.push_back(mk(0, 1, 1, 4'h0, 4'hf, 1, 0, 0, 1, 4'h0));
        t.push_back(mk(0, 0, 1, 4'h0, 4'hf, 0, 1, 1, 1, 4'h0));
        t.push_back(mk(0, 0, 1, 4'h0, 4'hf, 0, 1, 1, 1, 4'hf));
        t.push_back(mk(0, 0, 0, 4'h0, 4'hf, 0, 0, 1, 1, 4'hf));
        t.push_back(mk(0, 0, 0, 4'h0, 4'hf, 0, 0, 1, 0, 4'hf));
        foreach (t[i]) begin
            drive(t[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL back_to_back row %0d: got %b want %b",
                         i, obs(), e);
            end
        end
    endtask

    task automatic test_withdraw();
        row_t t[$];
        logic [W+3:0] e;
        t.push_back(mk(0, 1, 0, 4'h2, 4'h3, 1, 0, 0, 0, 4'hf));
        t.push_back(mk(0, 1, 1, 4'h2, 4'h3, 1, 0, 0, 1, 4'h2));
        t.push_back(mk(0, 1, 0, 4'h2, 4'h3, 1, 0, 0, 1, 4'h2));
        t.push_back(mk(0, 0, 0, 4'h2, 4'h3, 0, 0, 0, 1, 4'h2));
        t.push_back(mk(0, 0, 0, 4'h2, 4'h3, 0, 0, 0, 0, 4'h2));
        foreach (t[i]) begin
            drive(t[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL withdraw row %0d: got %b want %b",
                         i, obs(), e);
            end
        end
    endtask

    task automatic test_timeout();
        row_t t[$];
        logic [W+3:0] e;
        logic own_b;
        logic prev_b;
        t.push_back(mk(1, 1, 1, 4'h5, 4'ha, 0, 0, 0, 0, 4'h0));
        prev_b = 1'b0;
        for (int i = 1; i <= 20; i++) begin
`ifdef MUX_ARB_TIMEOUT_EN
            own_b = (((i - 1) / 4) % 2) == 1;
`else
            own_b = 1'b0;
`endif
            t.push_back(mk(0, 1, 1, 4'h5, 4'ha, !own_b, own_b, own_b,
                           i > 1, (i == 1) ? 4'h0 : (prev_b ? 4'ha : 4'h5)));
            prev_b = own_b;
        end
        t.push_back(mk(0, 0, 0, 4'h5, 4'ha, 0, 0, prev_b, 1,
                       prev_b ? 4'ha : 4'h5));
        foreach (t[i]) begin
            drive(t[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL timeout row %0d: got %b want %b",
                         i, obs(), e);
            end
        end
    endtask

    task automatic test_reset_mid();
        row_t t[$];
        logic [W+3:0] e;
        t.push_back(mk(0, 0, 1, 4'h5, 4'h9, 0, 1, 1, 0, 4'h5));
        t.push_back(mk(0, 0, 1, 4'h5, 4'h9, 0, 1, 1, 1, 4'h9));
        t.push_back(mk(1, 1, 1, 4'h5, 4'h9, 0, 0, 0, 0, 4'h0));
        t.push_back(mk(0, 1, 1, 4'h5, 4'h9, 1, 0, 0, 0, 4'h0));
        t.push_back(mk(0, 0, 0, 4'h6, 4'h9, 0, 0, 0, 1, 4'h6));
        t.push_back(mk(0, 0, 0, 4'h6, 4'h9, 0, 0, 0, 0, 4'h6));
        foreach (t[i]) begin
            drive(t[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL reset_mid row %0d: got %b want %b",
                         i, obs(), e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back();
        test_withdraw();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
